hash_query_controller: RTL

//  Query-phase counterpart of the hash generation controller: reads back the hash table that generation wrote to SRAM.
//  Per incoming k-mer: steps the LFSRs NUM_HASH times, reads one SRAM row per probe, tests the addressed bit.

---
 rtl/hash_query_pkg.sv | 35 +++
 rtl/query_bit_select.sv | 30 +++
 rtl/hash_query_controller.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/hash_query_pkg.sv
// Shared types and defaults for the hash-table query controller.
// The early-exit probe behaviour is selected in the top level by the
// HASH_QUERY_EARLY_EXIT_EN macro; nothing in this package depends on it.
package hash_query_pkg;

    // Default geometry of one query pass and of the SRAM holding the table
    localparam int DEF_NUM_KMERS = 212;
    localparam int DEF_NUM_HASH  = 2;
    localparam int DEF_ROW_W     = 32;
    localparam int DEF_IDX_W     = 5;
    localparam int DEF_CNT_W     = 8;

    // SRAM control pins are active low; these are their inactive levels
    localparam logic CSB_IDLE = 1'b1;
    localparam logic OEB_IDLE = 1'b1;
    localparam logic WEB_IDLE = 1'b1;

    // Controller states, one probe being HASH -> SET_ADDR -> READ_ROW -> CHECK
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_KMER = 3'd1,
        HASH      = 3'd2,
        SET_ADDR  = 3'd3,
        READ_ROW  = 3'd4,
        CHECK     = 3'd5,
        RESULT    = 3'd6,
        DONE      = 3'd7
    } state_t;

    // Width of the probe counter; a single-probe build still needs one bit
    function automatic int probe_cnt_width(input int num_hash);
        return (num_hash > 1) ? $clog2(num_hash) : 1;
    endfunction

endpackage

// File: rtl/query_bit_select.sv
// Holds the SRAM row read for the current probe and picks out the bit
// addressed by the current hash value.
module query_bit_select
    import hash_query_pkg::*;
#(
    parameter int ROW_W = DEF_ROW_W,
    parameter int IDX_W = DEF_IDX_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             capture,
    input  logic [ROW_W-1:0] sram_rdata,
    input  logic [IDX_W-1:0] bit_idx,
    output logic             probe_bit
);

    logic [ROW_W-1:0] row_q;

    // Capture the row at the end of the SRAM read cycle so CHECK sees stable data
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_q <= '0;
        end else if (capture) begin
            row_q <= sram_rdata;
        end
    end

    assign probe_bit = row_q[bit_idx];

endmodule

// File: rtl/hash_query_controller.sv
// Query-phase controller for the k-mer hash table held in SRAM.
// For each accepted k-mer it steps the hash LFSRs once per probe, reads the
// addressed SRAM row, tests one bit, and reports membership (all probe bits
// set) plus a running hit count for the pass.
// Build option: define HASH_QUERY_EARLY_EXIT_EN to stop probing a k-mer as
// soon as one probe bit reads 0 (variable latency); otherwise every probe
// runs and latency is fixed.
module hash_query_controller
    import hash_query_pkg::*;
#(
    parameter int NUM_KMERS = DEF_NUM_KMERS,
    parameter int NUM_HASH  = DEF_NUM_HASH,
    parameter int ROW_W     = DEF_ROW_W,
    parameter int IDX_W     = DEF_IDX_W,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_query,
    input  logic             kmer_valid,
    output logic             kmer_ready,
    output logic             EN_LFSR,
    output logic             read_add,
    output logic             CSB,
    output logic             OEB,
    output logic             WEB,
    input  logic [ROW_W-1:0] sram_rdata,
    input  logic [IDX_W-1:0] bit_idx,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             result_hit,
    output logic [CNT_W-1:0] hit_count,
    output logic             query_done
);

    localparam int PROBE_W = probe_cnt_width(NUM_HASH);

    state_t               state;
    state_t               state_next;
    logic [PROBE_W-1:0]   probe_cnt;
    logic [CNT_W-1:0]     kmer_cnt;
    logic                 hit_acc;
    logic                 probe_bit;
    logic                 row_capture;
    logic                 probe_last;
    logic                 kmer_last;

    assign probe_last = (probe_cnt == PROBE_W'(NUM_HASH - 1));
    assign kmer_last  = (kmer_cnt == CNT_W'(NUM_KMERS - 1));

    // This block never writes the table
    assign WEB = WEB_IDLE;

    query_bit_select #(
        .ROW_W (ROW_W),
        .IDX_W (IDX_W)
    ) u_bit_select (
        .clk        (clk),
        .reset      (reset),
        .capture    (row_capture),
        .sram_rdata (sram_rdata),
        .bit_idx    (bit_idx),
        .probe_bit  (probe_bit)
    );

    // State register; an asynchronous reset aborts any pass in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Probe/k-mer bookkeeping and the per-pass hit counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            probe_cnt <= '0;
            kmer_cnt  <= '0;
            hit_acc   <= 1'b0;
            hit_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_query) begin
                        hit_count <= '0;
                        kmer_cnt  <= '0;
                    end
                end
                WAIT_KMER: begin
                    if (kmer_valid) begin
                        probe_cnt <= '0;
                        hit_acc   <= 1'b1;
                    end
                end
                CHECK: begin
                    hit_acc   <= hit_acc & probe_bit;
                    probe_cnt <= probe_cnt + PROBE_W'(1);
                end
                RESULT: begin
                    if (result_ready) begin
                        hit_count <= hit_count + CNT_W'(hit_acc);
                        kmer_cnt  <= kmer_cnt + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state decode and the per-state control outputs
    always_comb begin
        state_next   = state;
        kmer_ready   = 1'b0;
        EN_LFSR      = 1'b0;
        read_add     = 1'b0;
        CSB          = CSB_IDLE;
        OEB          = OEB_IDLE;
        row_capture  = 1'b0;
        result_valid = 1'b0;
        result_hit   = 1'b0;
        query_done   = 1'b0;

        case (state)
            IDLE: begin
                if (start_query) begin
                    state_next = WAIT_KMER;
                end
            end
            WAIT_KMER: begin
                kmer_ready = 1'b1;
                if (kmer_valid) begin
                    state_next = HASH;
                end
            end
            HASH: begin
                EN_LFSR    = 1'b1;
                state_next = SET_ADDR;
            end
            SET_ADDR: begin
                read_add   = 1'b1;
                CSB        = 1'b0;
                OEB        = 1'b0;
                state_next = READ_ROW;
            end
            READ_ROW: begin
                CSB         = 1'b0;
                OEB         = 1'b0;
                row_capture = 1'b1;
                state_next  = CHECK;
            end
            CHECK: begin
`ifdef HASH_QUERY_EARLY_EXIT_EN
                if (!probe_bit || probe_last) begin
                    state_next = RESULT;
                end else begin
                    state_next = HASH;
                end
`else
                if (probe_last) begin
                    state_next = RESULT;
                end else begin
                    state_next = HASH;
                end
`endif
            end
            RESULT: begin
                result_valid = 1'b1;
                result_hit   = hit_acc;
                if (result_ready) begin
                    state_next = kmer_last ? DONE : WAIT_KMER;
                end
            end
            DONE: begin
                query_done = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
